// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped byte I/O port: register offsets,
// STATUS bit positions and the byte type.
package mmio_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t OFS_DATA   = 8'd0;
  localparam byte_t OFS_STATUS = 8'd1;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_RX_EMPTY = 1;
  localparam int STAT_TX_OVF   = 2;
  localparam int STAT_RX_UNF   = 3;

endpackage

// File: rtl/mmio_io_port_sync_fifo.sv
// Byte-wide synchronous FIFO. Full/empty come from the registered count, so a
// push to a full FIFO or a pop from an empty one is dropped regardless of the
// opposite operation in the same cycle.
module sync_fifo
  import mmio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  push_i,
  input  byte_t din_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output byte_t head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  byte_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the TX head reads 8'h00 out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_io_port.sv
// Memory-mapped byte I/O responder: DATA/STATUS decode, TX and RX FIFOs.
// Define MMIO_IO_PORT_ERR_EN to build the sticky overflow/underflow flags.
module mmio_io_port
  import mmio_pkg::*;
#(
  parameter byte_t BASE_ADDR = 8'hF0,
  parameter int    DEPTH     = 4
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  memWrite,
  input  logic  memRead,
  input  byte_t endereco,
  input  byte_t escreveDado,
  output byte_t leDado,
  output logic  hit,
  output byte_t tx_data,
  output logic  tx_valid,
  input  logic  tx_ready,
  input  byte_t rx_data,
  input  logic  rx_valid,
  output logic  rx_ready
);

  localparam byte_t ADDR_DATA   = BASE_ADDR + OFS_DATA;
  localparam byte_t ADDR_STATUS = BASE_ADDR + OFS_STATUS;

  logic  sel_data;
  logic  sel_status;
  logic  tx_full;
  logic  tx_empty;
  logic  rx_full;
  logic  rx_empty;
  byte_t rx_head;
  logic  tx_ovf;
  logic  rx_unf;
  byte_t status;

  assign sel_data   = (endereco == ADDR_DATA);
  assign sel_status = (endereco == ADDR_STATUS);
  assign hit        = sel_data || sel_status;

  sync_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (memWrite && sel_data),
    .din_i   (escreveDado),
    .pop_i   (tx_ready),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .head_o  (tx_data)
  );

  sync_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rx_valid),
    .din_i   (rx_data),
    .pop_i   (memRead && sel_data),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .head_o  (rx_head)
  );

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

`ifdef MMIO_IO_PORT_ERR_EN
  logic tx_ovf_q, tx_ovf_d;
  logic rx_unf_q, rx_unf_d;

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_unf_d = rx_unf_q;
    if (memWrite && sel_status) begin
      if (escreveDado[STAT_TX_OVF]) tx_ovf_d = 1'b0;
      if (escreveDado[STAT_RX_UNF]) rx_unf_d = 1'b0;
    end
    if (memWrite && sel_data && tx_full) tx_ovf_d = 1'b1;
    if (memRead && sel_data && rx_empty) rx_unf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  assign tx_ovf = tx_ovf_q;
  assign rx_unf = rx_unf_q;
`else
  assign tx_ovf = 1'b0;
  assign rx_unf = 1'b0;
`endif

  always_comb begin
    status                = '0;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_RX_EMPTY] = rx_empty;
    status[STAT_TX_OVF]   = tx_ovf;
    status[STAT_RX_UNF]   = rx_unf;
  end

  // An empty RX shows 8'h00 rather than the stale slot under the read pointer.
  always_comb begin
    leDado = '0;
    if (sel_data) leDado = rx_empty ? 8'h00 : rx_head;
    else if (sel_status) leDado = status;
  end

endmodule

// File: tb/tb_mmio_io_port.sv
// Directed self-checking bench for mmio_io_port (BASE_ADDR=8'hF0, DEPTH=4).
module tb_mmio_io_port;

`ifdef MMIO_IO_PORT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       memWrite, memRead;
  logic [7:0] endereco, escreveDado, leDado;
  logic       hit;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_io_port dut (
    .clock       (clk),
    .reset       (reset),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .endereco    (endereco),
    .escreveDado (escreveDado),
    .leDado      (leDado),
    .hit         (hit),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    endereco    = a;
    escreveDado = d;
    memWrite    = 1'b1;
    memRead     = 1'b0;
    step();
    memWrite    = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    memWrite = 0; memRead = 0; endereco = 8'h00; escreveDado = 8'h00;
    tx_ready = 0; rx_valid = 0; rx_data = 8'h00;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    endereco = 8'hF1; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h02) begin errors++; $display("FAIL reset_status got %h exp %h", leDado, 8'h02); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL reset_hit got %b exp 1", hit); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    memRead = 1'b0;
  endtask

  task automatic test_tx_order();
    logic [7:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    tx_ready = 1'b0;
    store(8'hF0, exp[0]);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL tx_latency got %b exp 1", tx_valid); end
    store(8'hF0, exp[1]);
    store(8'hF0, exp[2]);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (tx_data !== exp[i]) begin errors++; $display("FAIL tx_order[%0d] got %h exp %h", i, tx_data, exp[i]); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_drained got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_st;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(8'hF0, 8'h11 + 8'(i));
    endereco = 8'hF1; memRead = 1'b1; #1;
    exp_st = ERR_EN ? 8'h07 : 8'h03;
    checks++; if (leDado !== exp_st) begin errors++; $display("FAIL ovf_status got %h exp %h", leDado, exp_st); end
    memRead = 1'b0;
    store(8'hF1, 8'h04);
    endereco = 8'hF1; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h03) begin errors++; $display("FAIL ovf_clear got %h exp 03", leDado); end
    memRead = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (tx_data !== 8'h11 + 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, tx_data, 8'h11 + 8'(i)); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_fifth_dropped got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    logic [7:0] exp_st;
    rx_push(8'h5A);
    endereco = 8'hF0; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h5A) begin errors++; $display("FAIL rx_read got %h exp 5A", leDado); end
    step();
    checks++; if (leDado !== 8'h00) begin errors++; $display("FAIL rx_empty_read got %h exp 00", leDado); end
    step();
    memRead = 1'b0;
    endereco = 8'hF1; memRead = 1'b1; #1;
    exp_st = ERR_EN ? 8'h0A : 8'h02;
    checks++; if (leDado !== exp_st) begin errors++; $display("FAIL rx_unf_status got %h exp %h", leDado, exp_st); end
    memRead = 1'b0;
    store(8'hF1, 8'h08);
    endereco = 8'hF1; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h02) begin errors++; $display("FAIL rx_unf_clear got %h exp 02", leDado); end
    memRead = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_data = 8'h21 + 8'(i); rx_valid = 1'b1;
      step();
    end
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready got %b exp 0", rx_ready); end
    endereco = 8'hF0; memRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (leDado !== 8'h21 + 8'(i)) begin errors++; $display("FAIL rx_drain[%0d] got %h exp %h", i, leDado, 8'h21 + 8'(i)); end
      step();
    end
    checks++; if (leDado !== 8'h00) begin errors++; $display("FAIL rx_after_drain got %h exp 00", leDado); end
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL rx_ready_after_drain got %b exp 1", rx_ready); end
    memRead = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_st;
    tx_ready = 1'b0;
    store(8'hF0, 8'h31);
    store(8'hF0, 8'h32);
    endereco = 8'hF0; escreveDado = 8'h33; memWrite = 1'b1; tx_ready = 1'b1; #1;
    checks++; if (tx_data !== 8'h31) begin errors++; $display("FAIL b2b_head got %h exp 31", tx_data); end
    step();
    memWrite = 1'b0; tx_ready = 1'b0;
    checks++; if (tx_data !== 8'h32) begin errors++; $display("FAIL b2b_next got %h exp 32", tx_data); end
    tx_ready = 1'b1;
    step();
    checks++; if (tx_data !== 8'h33) begin errors++; $display("FAIL b2b_last got %h exp 33", tx_data); end
    step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_count got %b exp 0", tx_valid); end
    tx_ready = 1'b0;

    for (int i = 0; i < 4; i++) store(8'hF0, 8'h41 + 8'(i));
    endereco = 8'hF0; escreveDado = 8'h45; memWrite = 1'b1; tx_ready = 1'b1;
    step();
    memWrite = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++; if (tx_data !== 8'h41 + 8'(i)) begin errors++; $display("FAIL full_pushpop[%0d] got %h exp %h", i, tx_data, 8'h41 + 8'(i)); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL full_push_dropped got %b exp 0", tx_valid); end
    tx_ready = 1'b0;

    rx_push(8'h66);
    endereco = 8'hF0; escreveDado = 8'h77; memWrite = 1'b1; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h66) begin errors++; $display("FAIL rw_read got %h exp 66", leDado); end
    step();
    memWrite = 1'b0; memRead = 1'b0;
    checks++; if (tx_data !== 8'h77 || tx_valid !== 1'b1) begin errors++; $display("FAIL rw_write got %h/%b exp 77/1", tx_data, tx_valid); end
    endereco = 8'hF1; memRead = 1'b1; #1;
    exp_st = ERR_EN ? 8'h06 : 8'h02;
    checks++; if (leDado !== exp_st) begin errors++; $display("FAIL rw_status got %h exp %h", leDado, exp_st); end
    memRead = 1'b0;

    store(8'hF0, 8'h88);
    rx_data = 8'h99; rx_valid = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0; rx_valid = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midreset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midreset_tx_data got %h exp 00", tx_data); end
    endereco = 8'hF1; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h02) begin errors++; $display("FAIL midreset_status got %h exp 02", leDado); end
    memRead = 1'b0;
  endtask

  task automatic test_miss();
    rx_push(8'h3C);
    endereco = 8'h10; escreveDado = 8'h99; memWrite = 1'b1; memRead = 1'b1; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", hit); end
    checks++; if (leDado !== 8'h00) begin errors++; $display("FAIL miss_data got %h exp 00", leDado); end
    step();
    memWrite = 1'b0; memRead = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL miss_no_push got %b exp 0", tx_valid); end
    endereco = 8'hF0; memRead = 1'b1; #1;
    checks++; if (leDado !== 8'h3C) begin errors++; $display("FAIL miss_no_pop got %h exp 3C", leDado); end
    memRead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_overflow();
    test_rx();
    test_back_to_back();
    test_miss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_io_port.md
# mmio_io_port

Memory-mapped byte I/O responder on the nRisc data-memory bus. It decodes the processor's load/store strobes at a fixed base address and sits beside `data_memory` on the same bus. It exposes a transmit FIFO that the processor fills with stores and an external sink drains. It also exposes a receive FIFO that an external source fills and the processor drains with loads. The top level muxes `leDado` between this block and `data_memory` using `hit`.

## Interface
Parameters:
- `BASE_ADDR`, default 8'hF0: byte address of the DATA register. STATUS is at `BASE_ADDR+1`.
- `DEPTH`, default 4: entries per FIFO. Must be a power of 2, at least 2.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `memWrite` in 1: processor store strobe.
- `memRead` in 1: processor load strobe.
- `endereco` in 8: bus address.
- `escreveDado` in 8: store data.
- `leDado` out 8: load data, combinational.
- `hit` out 1: `endereco` is DATA or STATUS. Combinational; used by the top-level mux.
- `tx_data` out 8: TX FIFO head.
- `tx_valid` out 1: TX FIFO not empty.
- `tx_ready` in 1: external sink accepts.
- `rx_data` in 8: external source byte.
- `rx_valid` in 1: external source offers a byte.
- `rx_ready` out 1: RX FIFO not full.

## Operation
- Processor store to DATA (`memWrite` with DATA address): pushes `escreveDado` into TX if TX is not full. Otherwise the byte is dropped and the overflow flag is set.
- Processor load from DATA (`memRead` with DATA address):
  - `leDado` shows the RX head in the same cycle.
  - The pop happens at the clock edge.
  - If RX is empty, `leDado` is 8'h00, nothing is popped, and the underflow flag is set.
- Processor load from STATUS: `leDado` = {4'b0, rx_underflow, tx_overflow, rx_empty, tx_full}.
- Processor store to STATUS: each bit 3:2 written as 1 clears the matching sticky flag. Bits 1:0 are ignored.
- Outside DATA/STATUS addresses: `hit`=0, `leDado`=8'h00, no state change.
- External TX side: a transfer occurs on an edge where `tx_valid && tx_ready`. `tx_data` then advances to the next entry.
- External RX side: a transfer occurs on an edge where `rx_valid && rx_ready`. Pushes `rx_data`.
- Full and empty are evaluated before the edge:
  - A push to a full FIFO is dropped even if a pop happens in the same cycle.
  - A pop from an empty FIFO is ignored even if a push happens in the same cycle.
- Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged, data order preserved.
- `memRead` and `memWrite` both asserted to the same address: both actions take effect. Reading DATA pops RX; writing DATA pushes TX; they are independent queues.
- Pointers wrap modulo `DEPTH`. Count width is clog2(DEPTH)+1 so that the full and empty states are distinct.

## Timing
- Reset values:
  - `tx_valid`=0 and `tx_data`=8'h00 (FIFO storage cleared).
  - `rx_ready`=1.
  - `leDado` follows the inputs: STATUS reads 8'h02 (RX empty).
  - All pointers, counts and sticky flags are 0.
- Reset has priority over every simultaneous strobe. A reset asserted mid-stream discards all FIFO contents at that edge.
- Store-to-`tx_valid` latency: 1 edge.
- `rx_valid`-accept to data visible at DATA: 1 edge.
- Load data is combinational, so a single-cycle nRisc `lw` completes in its own cycle.
- Status flags reflect state after the most recent edge. No internal bypass: a byte pushed in cycle N is readable from cycle N+1.

## Configuration
- `MMIO_IO_PORT_ERR_EN` defined:
  - Sticky `tx_overflow` and `rx_underflow` flags are implemented.
  - STATUS writes clear them as described above.
- Not defined:
  - The flags are not built; STATUS bits 3:2 read 0.
  - STATUS writes have no effect.
  - Dropped pushes and empty pops are still silently ignored.

## Structure
- Shared package `mmio_pkg`:
  - Register offsets `OFS_DATA`=0 and `OFS_STATUS`=1.
  - STATUS bit-index constants.
  - Typedef `byte_t` (logic [7:0]).
- Sub-module `sync_fifo` (8-bit data, `DEPTH` parameter): push, pop, full, empty, head, synchronous active-high reset. Instantiated twice, once for TX and once for RX.
- Top-level `mmio_io_port`: address decode, read mux and sticky flags.

## Test plan
- Reset, then load STATUS -> `leDado`=8'h02, `tx_valid`=0, `rx_ready`=1, `hit`=1.
- Store 8'hA1, 8'hB2, 8'hC3 to DATA with `tx_ready`=0. Then hold `tx_ready`=1 -> `tx_data` sequence is A1, B2, C3, after which `tx_valid` falls.
- Store 5 bytes with `DEPTH`=4 and `tx_ready`=0 -> fifth byte dropped, STATUS=8'h07. Store 8'h04 to STATUS -> STATUS=8'h03.
- Drive `rx_data`=8'h5A with `rx_valid` for 1 cycle, then load DATA -> `leDado`=8'h5A and the FIFO pops. Next load of DATA -> `leDado`=8'h00 and STATUS bit3=1.
- With TX holding 2 entries, store to DATA while `tx_ready`=1 -> count stays 2 and order is preserved. Assert `reset` mid-stream -> `tx_valid`=0 on the next cycle.
- Load from 8'h10 -> `hit`=0, `leDado`=8'h00, no FIFO change.
